// File: rtl/mac_dot_seq.sv
// Dot-product sequencer driving one non_vector_MAC_int; MAC output is fed back as the accumulate input.
// Optional feature: define MAC_BIAS_EN to add a bias port that preloads the accumulator.

module non_vector_MAC_int #(
    parameter int REG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  logic [REG_WIDTH-1:0] c,
    output logic [REG_WIDTH-1:0] c_ab
);
    always_ff @(posedge clk) begin
        c_ab <= a * b + c;
    end
endmodule

// state | meaning
// IDLE  | waiting for start; MAC preloads INIT when start is seen
// RUN   | consuming operand pairs; counter holds pairs still to take
// DONE  | result presented on out_result until out_ready
module mac_dot_seq #(
    parameter int REG_WIDTH = 16,
    parameter int LEN_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] a_in,
    input  logic [REG_WIDTH-1:0] b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MAC_BIAS_EN
    input  logic [REG_WIDTH-1:0] bias,
`endif
    output logic [REG_WIDTH-1:0] out_result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [LEN_W-1:0]     cnt;
    logic [REG_WIDTH-1:0] mac_a;
    logic [REG_WIDTH-1:0] mac_b;
    logic [REG_WIDTH-1:0] mac_c;
    logic [REG_WIDTH-1:0] c_ab;
    logic [REG_WIDTH-1:0] init_val;
    logic                 hs;

`ifdef MAC_BIAS_EN
    assign init_val = bias;
`else
    assign init_val = '0;
`endif

    assign hs = in_valid & in_ready;

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (!rst) begin
            case (state)
                IDLE: mac_c = start ? init_val : '0;
                RUN: begin
                    mac_c = c_ab;
                    if (hs) begin
                        mac_a = a_in;
                        mac_b = b_in;
                    end
                end
                DONE:    mac_c = c_ab;
                default: mac_c = '0;
            endcase
        end
    end

    non_vector_MAC_int #(.REG_WIDTH(REG_WIDTH)) u_mac (
        .clk  (clk),
        .a    (mac_a),
        .b    (mac_b),
        .c    (mac_c),
        .c_ab (c_ab)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= RUN;
                            cnt      <= len;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // c_ab is final in the same cycle out_valid rises, so the result is taken straight from it
    assign out_result = out_valid ? c_ab : '0;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq: expected sums are queued when a vector is driven and compared when the result appears.
module tb_mac_dot_seq;
    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
`ifdef MAC_BIAS_EN
    logic [W-1:0]  bias = '0;
`endif

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    logic [W-1:0] exp_v;

    always #5 clk = ~clk;

    mac_dot_seq #(.REG_WIDTH(W), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MAC_BIAS_EN
        .bias       (bias),
`endif
        .out_result (out_result)
    );

    // Drives start plus len=va.size() pairs from va/vb with `gap` idle cycles between pairs.
    // Returns at the negedge following the last handshake edge.
    task automatic drive_vec(input int gap, input logic [W-1:0] bias_v);
        logic [W-1:0] acc;
        int n;
        int guard;
        n = va.size();
        acc = bias_v;
        for (int i = 0; i < n; i++) acc = acc + va[i] * vb[i];
        exp_q.push_back(acc);
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        len = LW'(n);
`ifdef MAC_BIAS_EN
        bias = bias_v;
`endif
        @(negedge clk);
        start = 1'b0;
        len = '0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a_in = va[i];
            b_in = vb[i];
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: in_ready=%0b required=1", in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            a_in = '0;
            b_in = '0;
            if (i < n - 1)
                for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
        total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result: got=%h want=0", out_result); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        va = '{16'd2, 16'd4, 16'd6};
        vb = '{16'd3, 16'd5, 16'd7};
        drive_vec(0, 16'd0);
        exp_v = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: out_valid=%0b want=1", out_valid); end
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL basic_result: got=%0d want=%0d", out_result, exp_v); end
        total++; if (out_result !== 16'd68) begin bad++; $display("FAIL basic_68: got=%0d want=68", out_result); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got=%0b want=0", busy); end
        total++; if (out_result !== '0) begin bad++; $display("FAIL basic_result_zero: got=%h want=0", out_result); end
    endtask

    task automatic test_stall();
        va = '{16'd2, 16'd4, 16'd6};
        vb = '{16'd3, 16'd5, 16'd7};
        drive_vec(4, 16'd0);
        exp_v = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_hold[%0d]: got=%0b want=1", k, out_valid); end
            total++; if (out_result !== exp_v) begin bad++; $display("FAIL stall_result_hold[%0d]: got=%0d want=%0d", k, out_result, exp_v); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop: got=%0b want=0", out_valid); end
    endtask

    task automatic test_overflow();
        va = '{16'hFFFF, 16'h0100};
        vb = '{16'hFFFF, 16'h0100};
        drive_vec(0, 16'd0);
        exp_v = exp_q.pop_front();
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL overflow_result: got=%h want=%h", out_result, exp_v); end
        total++; if (out_result !== 16'h0001) begin bad++; $display("FAIL overflow_0001: got=%h want=0001", out_result); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_len0();
        logic [W-1:0] bv;
`ifdef MAC_BIAS_EN
        bv = 16'h1234;
`else
        bv = 16'h0000;
`endif
        va.delete();
        vb.delete();
        drive_vec(0, bv);
        exp_v = exp_q.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_latency: out_valid=%0b want=1", out_valid); end
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL len0_result: got=%h want=%h", out_result, exp_v); end
        start = 1'b1;
        len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        len = '0;
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL len0_start_ignored: got=%h want=%h", out_result, exp_v); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_no_restart: busy=%0b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL len0_in_ready: got=%0b want=0", in_ready); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1;
        len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        a_in = 16'd50;
        b_in = 16'd50;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%0b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready: got=%0b want=0", in_ready); end
        va = '{16'd3};
        vb = '{16'd3};
        drive_vec(0, 16'd0);
        exp_v = exp_q.pop_front();
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL abort_result: got=%0d want=%0d", out_result, exp_v); end
        total++; if (out_result !== 16'd9) begin bad++; $display("FAIL abort_9: got=%0d want=9", out_result); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 3; v++) begin
            va.delete();
            vb.delete();
            for (int i = 0; i <= v + 1; i++) begin
                va.push_back(W'($urandom));
                vb.push_back(W'($urandom));
            end
            drive_vec(0, 16'd0);
            exp_v = exp_q.pop_front();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got=%0b want=1", v, out_valid); end
            total++; if (out_result !== exp_v) begin bad++; $display("FAIL b2b_result[%0d]: got=%h want=%h", v, out_result, exp_v); end
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy=%0b want=0", busy); end
    endtask

`ifdef MAC_BIAS_EN
    task automatic test_bias();
        va = '{16'd1, 16'd2};
        vb = '{16'd1, 16'd2};
        drive_vec(0, 16'd10);
        exp_v = exp_q.pop_front();
        total++; if (out_result !== exp_v) begin bad++; $display("FAIL bias_result: got=%0d want=%0d", out_result, exp_v); end
        total++; if (out_result !== 16'd15) begin bad++; $display("FAIL bias_15: got=%0d want=15", out_result); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_len0();
        test_abort();
        test_back_to_back();
`ifdef MAC_BIAS_EN
        test_bias();
`endif
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: left=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule
